// File: rtl/ald_pkg.sv
// ald_pkg
// Shared constants for the ALD ladder-logic controller.
//   N_IN                  : number of conditioned input channels
//   DEBOUNCE_CYCLES_DEF   : default debounce window (10 ms at 50 MHz)
//   CH_*                  : channel indices into the input image, also used
//                           by the rung scanner to address contacts
package ald_pkg;

  localparam int N_IN                = 6;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;

  localparam int CH_START = 0;
  localparam int CH_STOP  = 1;
  localparam int CH_TP1   = 2;
  localparam int CH_TP2   = 3;
  localparam int CH_TP3   = 4;
  localparam int CH_TR    = 5;

endpackage

// File: rtl/ald_debounce_ch.sv
// ald_debounce_ch
// One input channel: 2-flop synchronizer on the inverted active-low input,
// a debounce counter and the accepted (stable) level.
// Ports:
//   clk         : system clock
//   rst         : asynchronous active-low reset
//   raw_n       : raw active-low input (released = 1)
//   stable      : registered debounced active-high level
//   stable_next : level stable takes on this edge (post-update value)
//   rise_ev     : stable goes 0->1 on this edge
//   fall_ev     : stable goes 1->0 on this edge
module ald_debounce_ch
  import ald_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = ald_pkg::DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic stable,
  output logic stable_next,
  output logic rise_ev,
  output logic fall_ev
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic             s1_r;
  logic             s2_r;
  logic             stable_r;
  logic [CNT_W-1:0] cnt_r;
  logic             accept_s;

  // Accept the synchronized level once it has differed for the full window.
  always_comb begin
    accept_s = 1'b0;
    if (s2_r != stable_r) begin
      if (cnt_r == CNT_LAST) begin
        accept_s = 1'b1;
      end else begin
        accept_s = 1'b0;
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  // Synchronizer, debounce counter and stable level. Any sample that
  // agrees with stable restarts the count, so a bounce never accumulates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_r     <= 1'b0;
      s2_r     <= 1'b0;
      stable_r <= 1'b0;
      cnt_r    <= CNT_ZERO;
    end else begin
      s1_r <= ~raw_n;
      s2_r <= s1_r;
      if (accept_s) begin
        stable_r <= s2_r;
        cnt_r    <= CNT_ZERO;
      end else if (s2_r != stable_r) begin
        stable_r <= stable_r;
        cnt_r    <= cnt_r + CNT_ONE;
      end else begin
        stable_r <= stable_r;
        cnt_r    <= CNT_ZERO;
      end
    end
  end

  assign stable      = stable_r;
  assign stable_next = accept_s ? s2_r : stable_r;
  assign rise_ev     = accept_s & s2_r;
  assign fall_ev     = accept_s & ~s2_r;

endmodule

// File: rtl/ald_input_conditioner.sv
// ald_input_conditioner
// Debounces the active-low controller inputs and freezes a PLC-style input
// image once per ladder scan. Edges between snapshots are accumulated so a
// short press/release is still seen by the scanner.
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   raw_n      : raw active-low inputs (start, stop, tp1, tp2, tp3, tr)
//   scan_start : snapshot request from the rung scanner
//   live_level : debounced active-high levels, continuously updated
//   img_level  : levels frozen at the last snapshot
//   img_rise   : 0->1 seen since the previous snapshot
//   img_fall   : 1->0 seen since the previous snapshot
//   img_valid  : one-cycle pulse, a new image is on img_*
module ald_input_conditioner
  import ald_pkg::*;
#(
  parameter int N_IN            = ald_pkg::N_IN,
  parameter int DEBOUNCE_CYCLES = ald_pkg::DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] raw_n,
  input  logic            scan_start,
  output logic [N_IN-1:0] live_level,
  output logic [N_IN-1:0] img_level,
  output logic [N_IN-1:0] img_rise,
  output logic [N_IN-1:0] img_fall,
  output logic            img_valid
);

  logic [N_IN-1:0] stable_s;
  logic [N_IN-1:0] stable_next_s;
  logic [N_IN-1:0] rise_ev_s;
  logic [N_IN-1:0] fall_ev_s;

  logic [N_IN-1:0] acc_rise_r;
  logic [N_IN-1:0] acc_fall_r;
  logic [N_IN-1:0] img_level_r;
  logic [N_IN-1:0] img_rise_r;
  logic [N_IN-1:0] img_fall_r;
  logic            img_valid_r;

  for (genvar i = 0; i < N_IN; i++) begin : g_ch
    ald_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .raw_n       (raw_n[i]),
      .stable      (stable_s[i]),
      .stable_next (stable_next_s[i]),
      .rise_ev     (rise_ev_s[i]),
      .fall_ev     (fall_ev_s[i])
    );
  end

  // Edge accumulators. An edge coinciding with scan_start goes straight
  // into that image, so the accumulators restart from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_rise_r <= {N_IN{1'b0}};
      acc_fall_r <= {N_IN{1'b0}};
    end else if (scan_start) begin
      acc_rise_r <= {N_IN{1'b0}};
      acc_fall_r <= {N_IN{1'b0}};
    end else begin
      acc_rise_r <= acc_rise_r | rise_ev_s;
      acc_fall_r <= acc_fall_r | fall_ev_s;
    end
  end

  // Snapshot registers: capture post-update levels and all pending edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      img_level_r <= {N_IN{1'b0}};
      img_rise_r  <= {N_IN{1'b0}};
      img_fall_r  <= {N_IN{1'b0}};
      img_valid_r <= 1'b0;
    end else if (scan_start) begin
      img_level_r <= stable_next_s;
      img_rise_r  <= acc_rise_r | rise_ev_s;
      img_fall_r  <= acc_fall_r | fall_ev_s;
      img_valid_r <= 1'b1;
    end else begin
      img_level_r <= img_level_r;
      img_rise_r  <= img_rise_r;
      img_fall_r  <= img_fall_r;
      img_valid_r <= 1'b0;
    end
  end

  assign live_level = stable_s;
  assign img_level  = img_level_r;
  assign img_rise   = img_rise_r;
  assign img_fall   = img_fall_r;
  assign img_valid  = img_valid_r;

endmodule

// File: tb/tb_ald_input_conditioner.sv
// tb_ald_input_conditioner
// Scoreboard bench: the driver predicts the DUT outputs for every clock edge
// with a window-based reference model and queues the prediction; a monitor
// pops one prediction per edge and compares it with the DUT.
module tb_ald_input_conditioner;

  localparam int N = 6;
  localparam int D = 4;
  localparam int H = D + 2;

  typedef struct packed {
    logic [N-1:0] live;
    logic         valid;
    logic [N-1:0] lvl;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] raw_n = 6'h3F;
  logic         scan_start = 1'b0;
  logic [N-1:0] live_level, img_level, img_rise, img_fall;
  logic         img_valid;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  // reference model state
  logic [H-1:0] hist [N];
  logic [N-1:0] m_stable, m_acc_r, m_acc_f, m_lvl, m_rise, m_fall;

  ald_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .raw_n      (raw_n),
    .scan_start (scan_start),
    .live_level (live_level),
    .img_level  (img_level),
    .img_rise   (img_rise),
    .img_fall   (img_fall),
    .img_valid  (img_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) hist[c] = '0;
    m_stable = '0; m_acc_r = '0; m_acc_f = '0;
    m_lvl = '0; m_rise = '0; m_fall = '0;
  endtask

  // Drive one clock edge worth of inputs and queue the predicted outputs.
  // A level is accepted when the synchronized input (two edges late) has
  // shown the opposite value on D consecutive edges.
  task automatic cyc(input logic [N-1:0] raw, input logic ss, input logic rst_v);
    exp_t e;
    logic [N-1:0] rise, fall;
    logic was_rst;
    @(negedge clk);
    was_rst = rst;
    raw_n = raw; scan_start = ss; rst = rst_v;
    rise = '0; fall = '0;
    if (!rst_v) begin
      model_reset();
      if (was_rst) begin
        #1;
        chk("async_rst_live", live_level, 6'h00);
        chk("async_rst_lvl", img_level, 6'h00);
        chk("async_rst_rise", img_rise, 6'h00);
        chk("async_rst_fall", img_fall, 6'h00);
        chk("async_rst_valid", {5'b0, img_valid}, 6'h00);
      end
      e = '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        bit all_diff;
        hist[c] = {hist[c][H-2:0], ~raw[c]};
        all_diff = 1'b1;
        for (int j = 2; j < H; j++)
          if (hist[c][j] == m_stable[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_stable[c] = ~m_stable[c];
          if (m_stable[c]) rise[c] = 1'b1; else fall[c] = 1'b1;
        end
      end
      e.valid = ss;
      if (ss) begin
        m_lvl  = m_stable;
        m_rise = m_acc_r | rise;
        m_fall = m_acc_f | fall;
        m_acc_r = '0; m_acc_f = '0;
      end else begin
        m_acc_r |= rise;
        m_acc_f |= fall;
      end
      e.live = m_stable; e.lvl = m_lvl; e.rise = m_rise; e.fall = m_fall;
    end
    exp_q.push_back(e);
  endtask

  task automatic run(input logic [N-1:0] raw, input int n);
    for (int i = 0; i < n; i++) cyc(raw, 1'b0, 1'b1);
  endtask

  // Monitor: one prediction per edge, compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("live_level", live_level, e.live);
      chk("img_valid", {5'b0, img_valid}, {5'b0, e.valid});
      chk("img_level", img_level, e.lvl);
      chk("img_rise", img_rise, e.rise);
      chk("img_fall", img_fall, e.fall);
    end
  end

  initial begin
    logic [N-1:0] r;
    model_reset();
    // 1: reset with keys released, then an empty image
    cyc(6'h3F, 1'b0, 1'b0);
    cyc(6'h3F, 1'b0, 1'b0);
    run(6'h3F, 3);
    cyc(6'h3F, 1'b1, 1'b1);
    run(6'h3F, 2);
    // 2: clean press on start, two snapshots
    run(6'h3E, 8);
    cyc(6'h3E, 1'b1, 1'b1);
    run(6'h3E, 3);
    cyc(6'h3E, 1'b1, 1'b1);
    run(6'h3F, 8);
    // 3: bounce on stop: low 3, high 1, low 3, then held low
    run(6'h3D, 3);
    run(6'h3F, 1);
    run(6'h3D, 3);
    run(6'h3D, 6);
    run(6'h3F, 8);
    cyc(6'h3F, 1'b1, 1'b1);
    // 4: press and release within one scan on tp1
    run(6'h3B, 10);
    run(6'h3F, 10);
    cyc(6'h3F, 1'b1, 1'b1);
    run(6'h3F, 2);
    // 5: snapshot on the very edge tr is accepted (sixth edge)
    run(6'h1F, 5);
    cyc(6'h1F, 1'b1, 1'b1);
    run(6'h1F, 3);
    cyc(6'h1F, 1'b1, 1'b1);
    run(6'h3F, 8);
    // held scan_start: snapshot every cycle
    for (int i = 0; i < 4; i++) cyc(6'h3F, 1'b1, 1'b1);
    // 6: reset with tp2 mid-count and a pending tp3 rise
    run(6'h2F, 7);
    run(6'h27, 4);
    cyc(6'h27, 1'b0, 1'b0);
    run(6'h3F, 3);
    cyc(6'h3F, 1'b1, 1'b1);
    run(6'h3F, 2);
    // randomized traffic
    r = 6'h3F;
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 6) == 0) r[c] = ~r[c];
      cyc(r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 399) != 0));
    end
    run(6'h3F, 3);
    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
